// File: rtl/fp_convert_sequencer.sv
// Sequences a two's-complement sample through an external sign-magnitude converter, then
// normalises it with a serial shifter and rounds it to an {S, E, F} float with value F * 2^E.
module fp_convert_sequencer #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  conv_d,
  input  logic             conv_s,
  input  logic [IN_W-1:0]  conv_sm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [SIG_W-1:0] out_f,
  output logic             out_sat,
  output logic             busy
);

  localparam int LZ_W = EXP_W + 1;
  localparam logic [LZ_W-1:0] LZ_MAX = LZ_W'(2**EXP_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [IN_W-1:0]  conv_d_q;
  logic [IN_W-1:0]  sh_q;
  logic [LZ_W-1:0]  lz_q;
  logic             sgn_q;
  logic             out_valid_q;
  logic             out_s_q;
  logic [EXP_W-1:0] out_e_q;
  logic [SIG_W-1:0] out_f_q;
  logic             out_sat_q;

  logic [SIG_W-1:0] f0_s;
  logic             rnd_s;
  logic [SIG_W:0]   f1_s;
  logic [LZ_W-1:0]  e0_s;
  logic [LZ_W-1:0]  e1_s;
  logic [SIG_W-1:0] f_s;
  logic [EXP_W-1:0] out_e_d;
  logic [SIG_W-1:0] out_f_d;
  logic             out_sat_d;

  // Rounding of the normalised window; an exponent carry past the top saturates the result.
  always_comb begin
    f0_s  = sh_q[IN_W-1 -: SIG_W];
    rnd_s = sh_q[IN_W-1-SIG_W];
    f1_s  = {1'b0, f0_s} + {{SIG_W{1'b0}}, rnd_s};
    e0_s  = LZ_MAX - lz_q;
    if (f1_s[SIG_W]) begin
      e1_s = e0_s + LZ_W'(1);
      f_s  = {1'b1, {(SIG_W-1){1'b0}}};
    end else begin
      e1_s = e0_s;
      f_s  = f1_s[SIG_W-1:0];
    end
    if (e1_s[EXP_W]) begin
      out_e_d   = '1;
      out_f_d   = '1;
      out_sat_d = 1'b1;
    end else begin
      out_e_d   = e1_s[EXP_W-1:0];
      out_f_d   = f_s;
      out_sat_d = 1'b0;
    end
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      conv_d_q    <= '0;
      sh_q        <= '0;
      lz_q        <= '0;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_f_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            conv_d_q <= in_data;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          sh_q    <= conv_sm;
          sgn_q   <= conv_s;
          lz_q    <= '0;
          state_q <= NORM;
        end
        // One bit per cycle; lz caps at 2**EXP_W so small magnitudes land at E=0.
        NORM: begin
          if (sh_q[IN_W-1] || (lz_q == LZ_MAX)) begin
            state_q <= ROUND;
          end else begin
            sh_q <= sh_q << 1;
            lz_q <= lz_q + LZ_W'(1);
          end
        end
        ROUND: begin
          out_s_q     <= sgn_q;
          out_e_q     <= out_e_d;
          out_f_q     <= out_f_d;
          out_sat_q   <= out_sat_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign conv_d    = conv_d_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fp_convert_sequencer.sv
// Directed bench for fp_convert_sequencer with a behavioural sign-magnitude converter.
module tb_fp_convert_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [11:0] conv_d;
  logic        conv_s;
  logic [11:0] conv_sm;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_sat;
  logic        busy;

  int n_cmp;
  int n_err;

  fp_convert_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .conv_d    (conv_d),
    .conv_s    (conv_s),
    .conv_sm   (conv_sm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  // External converter: sign plus magnitude, with -2048 clamped to 2047.
  assign conv_s  = conv_d[11];
  assign conv_sm = !conv_d[11] ? conv_d :
                   (conv_d == 12'h800) ? 12'h7FF : (12'd0 - conv_d);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [11:0] d);
    check_eq("ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("conv_d_after_accept", int'(conv_d), int'(d));
    check_eq("ready_after_accept", int'(in_ready), 0);
    check_eq("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_result(input int lat, input int s, input int e, input int f, input int sat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("latency", cyc, lat);
    check_eq("out_s", int'(out_s), s);
    check_eq("out_e", int'(out_e), e);
    check_eq("out_f", int'(out_f), f);
    check_eq("out_sat", int'(out_sat), sat);
  endtask

  task automatic handshake(input int e, input int f);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_after_hs", int'(out_valid), 0);
    check_eq("ready_after_hs", int'(in_ready), 1);
    check_eq("e_held_after_hs", int'(out_e), e);
    check_eq("f_held_after_hs", int'(out_f), f);
  endtask

  initial begin
    int seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 12'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_conv_d", int'(conv_d), 0);
    check_eq("rst_out_e", int'(out_e), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    accept(12'd0);      wait_result(11, 0, 0, 0, 0);  handshake(0, 0);
    accept(12'd422);    wait_result(6, 0, 5, 13, 0);  handshake(5, 13);
    accept(12'h800);    wait_result(4, 1, 7, 15, 1);  handshake(7, 15);
    accept(12'd125);    wait_result(8, 0, 4, 8, 0);   handshake(4, 8);
    accept(12'd46);     wait_result(9, 0, 2, 12, 0);  handshake(2, 12);
    accept(12'hE5A);    wait_result(6, 1, 5, 13, 0);  handshake(5, 13);

    // Stalled consumer, ignored in_valid pulses, then accept one cycle after the handshake.
    accept(12'd422);    wait_result(6, 0, 5, 13, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 12'd46;
      @(posedge clk); #1;
      check_eq("stall_valid", int'(out_valid), 1);
      check_eq("stall_e", int'(out_e), 5);
      check_eq("stall_f", int'(out_f), 13);
      check_eq("stall_ready", int'(in_ready), 0);
      check_eq("stall_conv_d", int'(conv_d), 422);
    end
    in_valid = 1'b1;
    in_data = 12'd46;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("b2b_valid_low", int'(out_valid), 0);
    check_eq("b2b_ready", int'(in_ready), 1);
    check_eq("b2b_not_taken", int'(conv_d), 422);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("b2b_taken", int'(conv_d), 46);
    check_eq("b2b_busy", int'(in_ready), 0);
    wait_result(9, 0, 2, 12, 0);
    handshake(2, 12);

    // Reset during NORM aborts the conversion.
    accept(12'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", int'(in_ready), 1);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_e", int'(out_e), 0);
    check_eq("abort_f", int'(out_f), 0);
    check_eq("abort_conv_d", int'(conv_d), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    accept(12'd1);      wait_result(11, 0, 0, 1, 0);  handshake(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
